fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side engine for the team's synchronous FIFO (syn_fifo).
- Accepts a burst command of N words and pops exactly N words via rden/empty, issuing pops only while the FIFO is not empty.
- Compensates the FIFO's 1-cycle read latency and presents the words as a valid/ready stream with a last marker.
- Sits between syn_fifo and any downstream consumer that can backpressure.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and output data.
- LEN_WIDTH, 8, width of burst length field; max burst 2^LEN_WIDTH-1 words.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  burst command offered.
- cmd_len  in  LEN_WIDTH  words to read in this burst.
- cmd_ready  out  1  engine can accept a command (IDLE).
- fifo_rden  out  1  pop request to FIFO.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop.
- m_data  out  DATA_WIDTH  output word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts word.
- m_last  out  1  marks final word of burst, qualified by m_valid.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse when burst complete.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - State IDLE, all counters 0, skid buffer empty.
  - Outputs after reset: cmd_ready=1, fifo_rden=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.
- Pop accepted = fifo_rden & ~fifo_empty; fifo_dout is captured on the following cycle.
- Out fire = m_valid & m_ready.
- Command accept = cmd_valid & cmd_ready.
  - Latches cmd_len into pop_remaining and beat_remaining.
  - Clears internal flags.
- States:
  - IDLE: on accept with cmd_len=0, go to DONE (no pops, no beats). On accept with cmd_len>0, go to READ.
  - READ: issue pops. When pop_remaining reaches 0 after the final accepted pop, go to DRAIN.
  - DRAIN: no pops. When out fire with beat_remaining==1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in DONE; the next command is accepted no earlier than the cycle after done.
- fifo_rden is combinational from registered state:
  - fifo_rden = (state==READ) & (pop_remaining!=0) & (occ + inflight - out_fire < 2).
  - occ: 2-entry skid buffer occupancy, 0..2.
  - inflight: 1 if a pop was accepted last cycle.
- fifo_rden may be asserted while fifo_empty=1. Such a cycle is not a pop: no counter change, nothing in flight.
- Throughput: with FIFO non-empty and m_ready=1 held, one word per cycle sustained.
  - First m_valid comes 2 cycles after command accept (pop at T+1, capture at T+2).
- Skid buffer: 2-entry FIFO; m_data/m_valid driven from its head.
  - Data is never dropped or duplicated.
  - m_data and m_last remain stable while m_valid=1 and m_ready=0.
- m_last = m_valid & (beat_remaining==1).
- Simultaneous capture and out fire: occ unchanged, order preserved.
- Widths:
  - Counters are LEN_WIDTH bits and never underflow; decrement only on accepted pop or out fire respectively.
  - occ is 2 bits.
- cmd_valid during busy is ignored (cmd_ready=0).
- Reset mid-burst: returns to IDLE next edge.
  - Buffered and in-flight words are discarded.
  - A word popped in the reset cycle is lost, and that is the required behaviour.

Optional Feature:
- Macro FIFO_BURST_READER_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [15:0].
  - Counts cycles in READ where fifo_rden=1 and fifo_empty=1.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on reset and on command accept.
  - Holds its value through DONE and IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- FIFO preloaded with 0x00..0x04, m_ready=1, cmd_len=5 -> rden high 5 cycles; m_data 0x00..0x04 on consecutive cycles; m_last with 0x04; done pulse once; cmd_ready back to 1.
- FIFO holds 3 words, cmd_len=7, 4 more words written 10 cycles later -> first 3 beats out; rden stays high with no pops while empty; beats 4..7 follow; exactly 7 beats. With the macro defined, stall_cycles equals the count of rden&empty cycles (≥9).
- FIFO full with 4 words, cmd_len=4, m_ready toggling 1,0,0,1,0,1,1 -> occ+inflight never exceeds 2; output order 0..3 intact; m_data stable during m_ready=0 cycles.
- cmd_len=0 -> no rden, no m_valid; done pulses in the cycle after accept; back in IDLE.
- cmd_len=9, rst asserted after 3 beats delivered -> next cycle m_valid=0, fifo_rden=0, busy=0, cmd_ready=1; a new cmd_len=2 then returns the next two FIFO words.
- Back-to-back commands of 3 and 4 with cmd_valid held -> second accepted only after the first done; 7 beats total; m_last on beats 3 and 7.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst read engine for syn_fifo with latency-compensating skid buffer (optional FIFO_BURST_READER_STALL_CNT_EN stall counter)
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  cmd_ready,
    output logic                  fifo_rden,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
`ifdef FIFO_BURST_READER_STALL_CNT_EN
    output logic                  done,
    output logic [15:0]           stall_cycles
`else
    output logic                  done
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [1:0]            state;
    logic [LEN_WIDTH-1:0]  pop_remaining;
    logic [LEN_WIDTH-1:0]  beat_remaining;
    logic                  inflight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;

    logic                  pop_accept;
    logic                  out_fire;
    logic                  cmd_accept;
    logic [2:0]            pending;

    // Handshake decode; pops are throttled so the skid buffer can always absorb every in-flight word
    assign m_valid    = (occ != 2'd0);
    assign out_fire   = m_valid & m_ready;
    assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, out_fire};
    assign fifo_rden  = (state == ST_READ) && (pop_remaining != '0) && (pending < 3'd2);
    assign pop_accept = fifo_rden & ~fifo_empty;
    assign cmd_ready  = (state == ST_IDLE);
    assign cmd_accept = cmd_valid & cmd_ready;
    assign m_data     = m_valid ? buf_head : '0;
    assign m_last     = m_valid && (beat_remaining == LEN_ONE);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    // Burst sequencing: pop phase, drain phase, one-cycle completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        state <= (cmd_len == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (pop_accept && (pop_remaining == LEN_ONE)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire && (beat_remaining == LEN_ONE)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Remaining pops and beats; each only moves on its own accepted handshake so neither can underflow
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_remaining  <= '0;
            beat_remaining <= '0;
        end else if (cmd_accept) begin
            pop_remaining  <= cmd_len;
            beat_remaining <= cmd_len;
        end else begin
            if (pop_accept) begin
                pop_remaining <= pop_remaining - LEN_ONE;
            end
            if (out_fire) begin
                beat_remaining <= beat_remaining - LEN_ONE;
            end
        end
    end

    // Track the pop whose data appears on fifo_dout in the following cycle
    always_ff @(posedge clk) begin
        if (rst || cmd_accept) begin
            inflight <= 1'b0;
        end else begin
            inflight <= pop_accept;
        end
    end

    // Two-entry skid buffer: capture returning FIFO data, present the head, shift on consumption
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else if (cmd_accept) begin
            occ <= 2'd0;
        end else begin
            case ({inflight, out_fire})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf_head <= fifo_dout;
                    end else begin
                        buf_tail <= fifo_dout;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_head <= fifo_dout;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_BURST_READER_STALL_CNT_EN
    // Count cycles spent requesting pops from an empty FIFO, saturating, held until the next command
    always_ff @(posedge clk) begin
        if (rst || cmd_accept) begin
            stall_cycles <= 16'h0000;
        end else if ((state == ST_READ) && fifo_rden && fifo_empty && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_len = 8'd0;
    logic       cmd_ready;
    logic       fifo_rden;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'd0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_last;
    logic       busy;
    logic       done;
`ifdef FIFO_BURST_READER_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .fifo_rden  (fifo_rden),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
`ifdef FIFO_BURST_READER_STALL_CNT_EN
        .done       (done),
        .stall_cycles (stall_cycles)
`else
        .done       (done)
`endif
    );

    always #5 clk = ~clk;

    // syn_fifo model: registered read data one cycle after an accepted pop
    logic [7:0] mem [0:255];
    int         wp = 0;
    int         rp = 0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       fifo_flush = 1'b0;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rp <= wp;
        end else begin
            if (fifo_rden && !fifo_empty) begin
                fifo_dout <= mem[rp % 256];
                rp <= rp + 1;
            end
            if (wr_en) begin
                mem[wp % 256] <= wr_data;
                wp <= wp + 1;
            end
        end
    end

    // Output/handshake monitor sampled on the falling edge
    logic [7:0] beat_data [0:255];
    logic       beat_last [0:255];
    int         beat_cyc  [0:255];
    int         beat_cnt = 0;
    int         cyc = 0;
    int         rden_cnt = 0;
    int         pop_cnt = 0;
    int         stall_cnt = 0;
    int         done_cnt = 0;
    int         hold_err = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m_valid && m_ready) begin
            beat_data[beat_cnt % 256] <= m_data;
            beat_last[beat_cnt % 256] <= m_last;
            beat_cyc[beat_cnt % 256]  <= cyc;
            beat_cnt <= beat_cnt + 1;
        end
        if (fifo_rden) rden_cnt <= rden_cnt + 1;
        if (fifo_rden && !fifo_empty) pop_cnt <= pop_cnt + 1;
        if (fifo_rden && fifo_empty) stall_cnt <= stall_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (prev_hold && (!m_valid || m_data !== prev_data || m_last !== prev_last)) begin
            hold_err <= hold_err + 1;
        end
        prev_hold <= m_valid && !m_ready;
        prev_data <= m_data;
        prev_last <= m_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        wr_en = 1'b1;
        wr_data = w;
        step();
        wr_en = 1'b0;
    endtask

    task automatic flush();
        fifo_flush = 1'b1;
        step();
        fifo_flush = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_len = len;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) break;
            step();
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 200; k++) begin
            if (done) break;
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%0b required 1", name, done);
        end
    endtask

    task automatic check_beats(input string name, input int b0, input int n, input logic [7:0] first, input int last_a, input int last_b);
        checks++;
        if (beat_cnt - b0 !== n) begin
            errors++;
            $display("FAIL %s_beat_count: got %0d required %0d", name, beat_cnt - b0, n);
        end
        for (int i = 0; i < n; i++) begin
            logic [7:0] exp_d;
            logic       exp_l;
            exp_d = first + 8'(i);
            exp_l = (i == last_a) || (i == last_b);
            checks++;
            if (beat_data[(b0 + i) % 256] !== exp_d || beat_last[(b0 + i) % 256] !== exp_l) begin
                errors++;
                $display("FAIL %s_beat%0d: data=%0h last=%0b required data=%0h last=%0b", name, i,
                         beat_data[(b0 + i) % 256], beat_last[(b0 + i) % 256], exp_d, exp_l);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({cmd_ready, fifo_rden, m_valid, m_last, busy, done} !== 6'b100000 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: rdy/rden/valid/last/busy/done=%b data=%0h required 100000 data=00",
                     {cmd_ready, fifo_rden, m_valid, m_last, busy, done}, m_data);
        end
        rst = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cmd_ready=%0b busy=%0b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        int b0, r0, d0;
        for (int i = 0; i < 5; i++) push(8'(i));
        m_ready = 1'b1;
        b0 = beat_cnt; r0 = rden_cnt; d0 = done_cnt;
        send_cmd(8'd5);
        checks++;
        if (fifo_rden !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_cycle: rden=%0b busy=%0b rdy=%0b valid=%0b required 1 1 0 0",
                     fifo_rden, busy, cmd_ready, m_valid);
        end
        step();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency_early: m_valid=%0b required 0", m_valid);
        end
        step();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL basic_first_beat: valid=%0b data=%0h required 1 00", m_valid, m_data);
        end
        wait_done("basic");
        step();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: done=%0b rdy=%0b busy=%0b required 0 1 0", done, cmd_ready, busy);
        end
        check_beats("basic", b0, 5, 8'h00, 4, -1);
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (beat_cyc[(b0 + i) % 256] - beat_cyc[(b0 + i - 1) % 256] !== 1) begin
                errors++;
                $display("FAIL basic_consecutive%0d: gap=%0d required 1", i,
                         beat_cyc[(b0 + i) % 256] - beat_cyc[(b0 + i - 1) % 256]);
            end
        end
        checks++;
        if (rden_cnt - r0 !== 5 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_rden_done: rden_cycles=%0d done_pulses=%0d required 5 1", rden_cnt - r0, done_cnt - d0);
        end
`ifdef FIFO_BURST_READER_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL basic_stall_cycles: got %0d required 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_stall();
        int b0, r0, p0, s0;
        for (int i = 0; i < 3; i++) push(8'h10 + 8'(i));
        b0 = beat_cnt; r0 = rden_cnt; p0 = pop_cnt; s0 = stall_cnt;
        send_cmd(8'd7);
        repeat (11) step();
        for (int i = 3; i < 7; i++) push(8'h10 + 8'(i));
        wait_done("stall");
        step();
        check_beats("stall", b0, 7, 8'h10, 6, -1);
        checks++;
        if (pop_cnt - p0 !== 7 || stall_cnt - s0 !== 9 || rden_cnt - r0 !== 16) begin
            errors++;
            $display("FAIL stall_counts: pops=%0d empty_rden=%0d rden=%0d required 7 9 16",
                     pop_cnt - p0, stall_cnt - s0, rden_cnt - r0);
        end
`ifdef FIFO_BURST_READER_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 16'd9) begin
            errors++;
            $display("FAIL stall_cycles_value: got %0d required 9", stall_cycles);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic pat [0:6];
        int b0, h0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        pat[4] = 1'b0; pat[5] = 1'b1; pat[6] = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        b0 = beat_cnt; h0 = hold_err;
        send_cmd(8'd4);
        for (int i = 0; i < 7; i++) begin
            m_ready = pat[i];
            step();
        end
        m_ready = 1'b1;
        wait_done("bp");
        step();
        check_beats("bp", b0, 4, 8'h20, 3, -1);
        checks++;
        if (hold_err - h0 !== 0) begin
            errors++;
            $display("FAIL bp_hold_stable: violations=%0d required 0", hold_err - h0);
        end
    endtask

    task automatic test_zero_len();
        int b0, r0;
        push(8'h5A);
        b0 = beat_cnt; r0 = rden_cnt;
        send_cmd(8'd0);
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || fifo_rden !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_cycle: done=%0b rdy=%0b rden=%0b valid=%0b required 1 0 0 0",
                     done, cmd_ready, fifo_rden, m_valid);
        end
        step();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: done=%0b rdy=%0b busy=%0b required 0 1 0", done, cmd_ready, busy);
        end
        checks++;
        if (beat_cnt - b0 !== 0 || rden_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL zero_activity: beats=%0d rden=%0d required 0 0", beat_cnt - b0, rden_cnt - r0);
        end
`ifdef FIFO_BURST_READER_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL zero_stall_clear: got %0d required 0", stall_cycles);
        end
`endif
        flush();
    endtask

    task automatic test_reset_mid();
        int fired, b0;
        for (int i = 0; i < 9; i++) push(8'h30 + 8'(i));
        m_ready = 1'b1;
        send_cmd(8'd9);
        fired = 0;
        for (int k = 0; k < 50 && fired < 3; k++) begin
            if (m_valid && m_ready) fired++;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || fifo_rden !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: valid=%0b rden=%0b busy=%0b rdy=%0b required 0 0 0 1",
                     m_valid, fifo_rden, busy, cmd_ready);
        end
        b0 = beat_cnt;
        send_cmd(8'd2);
        wait_done("midreset");
        step();
        check_beats("midreset", b0, 2, 8'h36, 1, -1);
        flush();
    endtask

    task automatic test_back_to_back();
        int b0;
        logic prev_done;
        for (int i = 0; i < 7; i++) push(8'h40 + 8'(i));
        m_ready = 1'b1;
        b0 = beat_cnt;
        cmd_valid = 1'b1;
        cmd_len = 8'd3;
        step();
        cmd_len = 8'd4;
        prev_done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (cmd_ready) break;
            prev_done = done;
            step();
        end
        checks++;
        if (cmd_ready !== 1'b1 || prev_done !== 1'b1 || beat_cnt - b0 !== 3) begin
            errors++;
            $display("FAIL b2b_second_accept: rdy=%0b prev_done=%0b beats=%0d required 1 1 3",
                     cmd_ready, prev_done, beat_cnt - b0);
        end
        step();
        cmd_valid = 1'b0;
        wait_done("b2b");
        step();
        check_beats("b2b", b0, 7, 8'h40, 2, 6);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
